// File: rtl/vid_addr_seq.sv
// Purpose : video address counter and word-fetch sequencer (22-bit screen address, vsync reload, CPU byte writes).
// Latency : first vld FETCH_DIV clocks after de is first sampled high; then one vld every FETCH_DIV clocks.
// Backpr. : none; fetch slots run free while de is high, consumers must accept every vld strobe.
//
// Ports:
//   c         system clock, rising edge
//   xr        asynchronous active-low reset
//   vsync     high on an edge loads base into the counter and returns to IDLE
//   base      screen base byte address (bit 0 ignored)
//   de        display enable
//   wr_sel    CPU byte-lane write select: [2]=addr[21:16], [1]=addr[15:8], [0]=addr[7:1]
//   wr_data   CPU write data
//   line_ofs  words added at end of each displayed line (used only with VID_LINE_OFFSET_EN)
//   vaddr     current video byte address, bit 0 always 0
//   vld       one-clock fetch strobe, vaddr is the fetch address
//   busy      high while in FETCH or EOL
//
// Optional feature: define VID_LINE_OFFSET_EN to add line_ofs at end of line;
// otherwise the EOL clock still happens but adds nothing.

module vid_addr_seq #(
    parameter int FETCH_DIV = 4,
    parameter int LOFS_W    = 8
) (
    input  logic              c,
    input  logic              xr,
    input  logic              vsync,
    input  logic [21:0]       base,
    input  logic              de,
    input  logic [2:0]        wr_sel,
    input  logic [7:0]        wr_data,
    input  logic [LOFS_W-1:0] line_ofs,
    output logic [21:0]       vaddr,
    output logic              vld,
    output logic              busy
);

    localparam int PW = (FETCH_DIV > 1) ? $clog2(FETCH_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(FETCH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EOL   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [20:0]   cnt_q, cnt_d;
    logic [20:0]   ofs_add;
    logic          slot_end;

`ifdef VID_LINE_OFFSET_EN
    assign ofs_add = 21'(line_ofs);
    logic unused_bits;
    assign unused_bits = base[0];
`else
    assign ofs_add = 21'd0;
    logic unused_bits;
    assign unused_bits = ^{base[0], line_ofs};
`endif

    // Last clock of a fetch slot; the increment lands on the edge ending it,
    // so vld always sees the pre-increment address.
    assign slot_end = (state_q == FETCH) && (ph_q == PH_LAST);

    always_ff @(posedge c or negedge xr) begin
        if (!xr) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (de) state_d = FETCH;
            end
            FETCH: begin
                // Dropping de mid-slot abandons it; a completed slot still
                // increments on this edge (handled below via slot_end).
                if (!de) begin
                    state_d = EOL;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            EOL: begin
                ph_d    = '0;
                state_d = de ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase

        // Counter update: CPU write beats offset add beats fetch increment.
        if (|wr_sel) begin
            if (wr_sel[2]) cnt_d[20:15] = wr_data[5:0];
            if (wr_sel[1]) cnt_d[14:7]  = wr_data;
            if (wr_sel[0]) cnt_d[6:0]   = wr_data[7:1];
        end else if (state_q == EOL) begin
            cnt_d = cnt_q + ofs_add;
        end else if (slot_end) begin
            cnt_d = cnt_q + 21'd1;
        end

        // vsync overrides everything, including a pending EOL.
        if (vsync) begin
            cnt_d   = base[21:1];
            ph_d    = '0;
            state_d = IDLE;
        end
    end

    assign vaddr = {cnt_q, 1'b0};
    assign vld   = slot_end;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_vid_addr_seq.sv
module tb_vid_addr_seq;

    localparam int D = 4;

`ifdef VID_LINE_OFFSET_EN
    localparam logic [21:0] OFS_BYTES = 22'h000020;
`else
    localparam logic [21:0] OFS_BYTES = 22'h000000;
`endif

    logic        c = 1'b0;
    logic        xr;
    logic        vsync;
    logic [21:0] base;
    logic        de;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [7:0]  line_ofs;
    logic [21:0] vaddr;
    logic        vld;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    vid_addr_seq #(.FETCH_DIV(D), .LOFS_W(8)) dut (
        .c(c), .xr(xr), .vsync(vsync), .base(base), .de(de),
        .wr_sel(wr_sel), .wr_data(wr_data), .line_ofs(line_ofs),
        .vaddr(vaddr), .vld(vld), .busy(busy)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word address, clocks elapsed in the current fetch
    // slot (-1 when no line is being fetched), and a pending end-of-line.
    logic [20:0] m_cnt = '0;
    int          m_run = -1;
    bit          m_eol = 1'b0;

    always @(posedge c or negedge xr) begin
        if (!xr) begin
            m_cnt = '0;
            m_run = -1;
            m_eol = 1'b0;
        end else begin
            logic [20:0] nc;
            logic [20:0] ofs;
            bit          done;
            nc   = m_cnt;
            done = (m_run == D - 1);
`ifdef VID_LINE_OFFSET_EN
            ofs = 21'(line_ofs);
`else
            ofs = 21'd0;
`endif
            if (vsync) begin
                m_cnt = base[21:1];
                m_run = -1;
                m_eol = 1'b0;
            end else begin
                if (wr_sel != 3'b000) begin
                    if (wr_sel[2]) nc = (nc & ~(21'h3F << 15)) | (21'(wr_data & 8'h3F) << 15);
                    if (wr_sel[1]) nc = (nc & ~(21'hFF << 7))  | (21'(wr_data) << 7);
                    if (wr_sel[0]) nc = (nc & ~21'h7F)         | 21'(wr_data >> 1);
                end else if (m_eol) begin
                    nc = nc + ofs;
                end else if (done) begin
                    nc = nc + 21'd1;
                end
                m_cnt = nc;
                if (m_eol) begin
                    m_eol = 1'b0;
                    m_run = de ? 0 : -1;
                end else if (m_run >= 0) begin
                    if (!de) begin
                        m_eol = 1'b1;
                        m_run = -1;
                    end else begin
                        m_run = (m_run + 1) % D;
                    end
                end else begin
                    m_run = de ? 0 : -1;
                end
            end
        end
    end

    always @(negedge c) begin
        if (cmp_en) begin
            chk("mdl_vaddr", 32'(vaddr), 32'({m_cnt, 1'b0}));
            chk("mdl_vld",   32'(vld),   32'(m_run == D - 1));
            chk("mdl_busy",  32'(busy),  32'((m_run >= 0) || m_eol));
        end
    end

    task automatic tick;
        @(posedge c);
        @(negedge c);
    endtask

    initial begin
        xr = 1'b1; vsync = 1'b1; de = 1'b1; base = 22'h0;
        wr_sel = 3'b000; wr_data = 8'h00; line_ofs = 8'h00;
        #2 xr = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset holds everything at zero despite vsync/de
        repeat (3) @(negedge c);
        chk("rst_vaddr", 32'(vaddr), 32'h0);
        chk("rst_vld",   32'(vld),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        vsync = 1'b0; de = 1'b0; xr = 1'b1;
        tick;

        // vsync load and two fetches
        base = 22'h078000; vsync = 1'b1; tick; vsync = 1'b0;
        chk("load_vaddr", 32'(vaddr), 32'h078000);
        chk("load_busy",  32'(busy),  32'h0);
        de = 1'b1; line_ofs = 8'h10;
        repeat (4) tick;
        chk("f1_vld",   32'(vld),   32'h1);
        chk("f1_vaddr", 32'(vaddr), 32'h078000);
        repeat (4) tick;
        chk("f2_vld",   32'(vld),   32'h1);
        chk("f2_vaddr", 32'(vaddr), 32'h078002);
        de = 1'b0; tick;
        chk("eol_busy",  32'(busy),  32'h1);
        chk("eol_vld",   32'(vld),   32'h0);
        chk("eol_vaddr", 32'(vaddr), 32'h078004);
        tick;
        chk("ofs_vaddr", 32'(vaddr), 32'(22'h078004 + OFS_BYTES));
        chk("ofs_busy",  32'(busy),  32'h0);

        // Wrap through CPU lane writes
        line_ofs = 8'h00;
        wr_sel = 3'b100; wr_data = 8'h3F; tick;
        wr_sel = 3'b010; wr_data = 8'hFF; tick;
        wr_sel = 3'b001; wr_data = 8'hFE; tick;
        wr_sel = 3'b000;
        chk("wr_vaddr", 32'(vaddr), 32'h3FFFFE);
        de = 1'b1; repeat (4) tick;
        chk("wrap_vld",   32'(vld),   32'h1);
        chk("wrap_pre",   32'(vaddr), 32'h3FFFFE);
        de = 1'b0; tick;
        chk("wrap_vaddr", 32'(vaddr), 32'h000000);
        tick;

        // CPU write collides with a fetch increment
        base = 22'h001000; vsync = 1'b1; tick; vsync = 1'b0;
        de = 1'b1; repeat (4) tick;
        chk("col_vld",   32'(vld),   32'h1);
        chk("col_pre",   32'(vaddr), 32'h001000);
        wr_sel = 3'b001; wr_data = 8'h40; tick; wr_sel = 3'b000;
        chk("col_vaddr", 32'(vaddr), 32'h001040);
        chk("col_vld2",  32'(vld),   32'h0);
        chk("col_busy",  32'(busy),  32'h1);
        de = 1'b0; tick; tick;

        // Abandoned slot: no fetch, only the line offset
        line_ofs = 8'h10; base = 22'h002000; vsync = 1'b1; tick; vsync = 1'b0;
        de = 1'b1; tick;
        chk("ab_vld0", 32'(vld), 32'h0);
        tick;
        chk("ab_vld1", 32'(vld), 32'h0);
        de = 1'b0; tick;
        chk("ab_eol",   32'(vaddr), 32'h002000);
        chk("ab_vld2",  32'(vld),   32'h0);
        tick;
        chk("ab_vaddr", 32'(vaddr), 32'(22'h002000 + OFS_BYTES));

        // vsync while de is high restarts the line
        de = 1'b1; tick; tick;
        base = 22'h100000; vsync = 1'b1; tick; vsync = 1'b0;
        chk("vs_busy0", 32'(busy),  32'h0);
        chk("vs_vaddr", 32'(vaddr), 32'h100000);
        tick;
        chk("vs_busy1", 32'(busy),  32'h1);
        repeat (3) tick;
        chk("vs_vld",   32'(vld),   32'h1);
        chk("vs_pre",   32'(vaddr), 32'h100000);
        de = 1'b0; tick; tick;

        // All lanes from one data byte
        wr_sel = 3'b111; wr_data = 8'h55; tick; wr_sel = 3'b000;
        chk("ml_vaddr", 32'(vaddr), 32'h155554);

        // Mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            vsync    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) de = ~de;
            wr_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            wr_data  = 8'($urandom);
            line_ofs = 8'($urandom);
            base     = 22'($urandom);
            tick;
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
